// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types, constants and helpers for the operand-2 shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int MAX_ITER  = 33;
  localparam int FAST_STEP = 4;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // Number of single-bit steps needed for a non-zero amount. Clamping at 33
  // (LSL/LSR) and 32 (ASR) reproduces the ARM large-amount results; ROR by a
  // non-zero multiple of 32 rotates all the way round so C picks up bit 31.
  function automatic logic [5:0] iter_count(input shift_type_e t, input logic [7:0] amt);
    logic [5:0] n;
    case (t)
      LSL, LSR: n = (amt > 8'(MAX_ITER)) ? 6'(MAX_ITER) : amt[5:0];
      ASR:      n = (amt > 8'd32) ? 6'd32 : amt[5:0];
      default:  n = ((amt[4:0] == 5'd0) && (amt != 8'd0)) ? 6'd32 : {1'b0, amt[4:0]};
    endcase
    return n;
  endfunction

  // NZCV as seen by the ALU; V is never produced by the shifter.
  function automatic logic [3:0] make_flags(input logic [31:0] d, input logic c);
    logic [3:0] f;
    f        = 4'b0000;
    f[N_BIT] = d[31];
    f[Z_BIT] = ~|d;
    f[C_BIT] = c;
    f[V_BIT] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// shift_step: combinational 1..4 bit shift of one operand with carry-out.
import shift_seq_pkg::*;

module shift_step (
  input  logic [31:0]  data_i,
  input  shift_type_e  type_i,
  input  logic [2:0]   amt_i,
  output logic [31:0]  data_o,
  output logic         carry_o
);

  // Unrolled chain of single-bit steps; amt_i is always at least 1 so carry_o
  // is always the last bit that left the word.
  always_comb begin
    data_o  = data_i;
    carry_o = 1'b0;
    for (int i = 0; i < FAST_STEP; i++) begin
      if (i < int'(amt_i)) begin
        case (type_i)
          LSL: begin
            carry_o = data_o[31];
            data_o  = {data_o[30:0], 1'b0};
          end
          LSR: begin
            carry_o = data_o[0];
            data_o  = {1'b0, data_o[31:1]};
          end
          ASR: begin
            carry_o = data_o[0];
            data_o  = {data_o[31], data_o[31:1]};
          end
          default: begin
            carry_o = data_o[0];
            data_o  = {data_o[0], data_o[31:1]};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle operand-2 shifter with request/response handshakes.
// Optional macro SHIFT_SEQ_FAST_EN: shift up to 4 bits per SHIFT cycle.
import shift_seq_pkg::*;

module shift_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [25:0] Instr,
  input  logic [31:0] Rm,
  input  logic [31:0] Rs,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] Rd,
  output logic [3:0]  ShifterFlags,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  shift_type_e type_q, type_d;
  logic [31:0] data_q, data_d;
  logic        c_q, c_d;
  logic [3:0]  flags_q, flags_d;

  logic [7:0]  req_amt;
  shift_type_e req_type;
  logic        req_pass;
  logic [5:0]  req_n;

  logic [2:0]  step_amt;
  logic [31:0] step_data;
  logic        step_c;

  // Decode the request: pick the amount source and derive the step count.
  always_comb begin
    req_amt  = Instr[4] ? Rs[7:0] : {3'b000, Instr[11:7]};
    req_type = shift_type_e'(Instr[6:5]);
    req_pass = Instr[25] | (Instr[11:4] == 8'd0) | (req_amt == 8'd0);
    req_n    = req_pass ? 6'd0 : iter_count(req_type, req_amt);
  end

`ifdef SHIFT_SEQ_FAST_EN
  assign step_amt = (cnt_q >= 6'(FAST_STEP)) ? 3'(FAST_STEP) : cnt_q[2:0];
`else
  assign step_amt = 3'd1;
`endif

  shift_step u_step (
    .data_i  (data_q),
    .type_i  (type_q),
    .amt_i   (step_amt),
    .data_o  (step_data),
    .carry_o (step_c)
  );

  // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    data_d  = data_q;
    c_d     = c_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_d = Rm;
          c_d    = 1'b0;
          type_d = req_type;
          cnt_d  = req_n;
          if (req_n == 6'd0) begin
            state_d = DONE;
            flags_d = make_flags(Rm, 1'b0);
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = step_data;
        c_d    = step_c;
        cnt_d  = cnt_q - {3'b000, step_amt};
        if (cnt_q == {3'b000, step_amt}) begin
          state_d = DONE;
          flags_d = make_flags(step_data, step_c);
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      type_q  <= LSL;
      data_q  <= 32'd0;
      c_q     <= 1'b0;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      data_q  <= data_d;
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  assign req_ready    = reset_n && (state_q == IDLE);
  assign resp_valid   = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign Rd           = data_q;
  assign ShifterFlags = flags_q;

endmodule
